// File: rtl/mii_pkg.sv
// mii_pkg: shared lane symbols, deframer states and FIFO entry layout for mii_rx_deframer
package mii_pkg;

    typedef logic [7:0] lane_sym_t;

    localparam lane_sym_t PRE_SYM_2 = 8'h01;
    localparam lane_sym_t PRE_SYM_4 = 8'h05;
    localparam lane_sym_t PRE_SYM_8 = 8'h55;
    localparam lane_sym_t SFD_SYM_2 = 8'h03;
    localparam lane_sym_t SFD_SYM_4 = 8'h0D;
    localparam lane_sym_t SFD_SYM_8 = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } deframer_state_e;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    function automatic lane_sym_t pre_sym(input int lane_w);
        return lane_w == 2 ? PRE_SYM_2 : lane_w == 4 ? PRE_SYM_4 : PRE_SYM_8;
    endfunction

    function automatic lane_sym_t sfd_sym(input int lane_w);
        return lane_w == 2 ? SFD_SYM_2 : lane_w == 4 ? SFD_SYM_4 : SFD_SYM_8;
    endfunction

endpackage

// File: rtl/mii_rx_fifo.sv
// mii_rx_fifo: first-word-fall-through FIFO of rx_entry_t; push while full is ignored
module mii_rx_fifo
    import mii_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_push,
    input  rx_entry_t i_entry,
    input  logic      i_pop,
    output rx_entry_t o_entry,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign o_full  = count == FULL_CNT;
    assign o_empty = count == '0;
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_entry = o_empty ? '0 : mem[rd_ptr];

    // pointers and occupancy; full is judged before this cycle's pop
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // entry storage, no reset needed since reads are masked while empty
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_entry;
    end

endmodule

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: lane receive deframer with FWFT byte FIFO; define MII_RX_DEFRAMER_STATS_EN for saturating frame counters
module mii_rx_deframer
    import mii_pkg::*;
#(
    parameter int LANE_W      = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int MIN_PRE_SYM = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rx_en,
    input  logic              i_rx_dv,
    input  logic              i_rx_er,
    input  logic [LANE_W-1:0] i_rx_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_data,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_err,
    output logic [15:0]       o_frames_ok,
    output logic [15:0]       o_frames_err,
    output logic [15:0]       o_frames_drop
);
    localparam logic [LANE_W-1:0] P_SYM    = LANE_W'(pre_sym(LANE_W));
    localparam logic [LANE_W-1:0] S_SYM    = LANE_W'(sfd_sym(LANE_W));
    localparam logic [1:0]        SYM_LAST = 2'(8 / LANE_W - 1);
    localparam logic [7:0]        MIN_PRE  = 8'(MIN_PRE_SYM);

    deframer_state_e state, state_d;
    logic [7:0] pre_cnt, pre_cnt_d;
    logic [7:0] asm_q, asm_d, asm_nx;
    logic [7:0] hold_q, hold_d;
    logic [1:0] sym_cnt, sym_d;
    logic       hold_v, hold_v_d;
    logic       sof_done, sof_d;
    logic       frame_err, ferr_d;
    logic       abort_q, abort_d;
    logic       push, full, empty, byte_done;
    logic       ok_inc, err_inc, drop_inc;
    rx_entry_t  push_e, head;

    assign asm_nx    = 8'({i_rx_data, asm_q} >> LANE_W);
    assign byte_done = sym_cnt == SYM_LAST;

    // deframer registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            asm_q     <= '0;
            hold_q    <= '0;
            sym_cnt   <= '0;
            hold_v    <= 1'b0;
            sof_done  <= 1'b0;
            frame_err <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state     <= state_d;
            pre_cnt   <= pre_cnt_d;
            asm_q     <= asm_d;
            hold_q    <= hold_d;
            sym_cnt   <= sym_d;
            hold_v    <= hold_v_d;
            sof_done  <= sof_d;
            frame_err <= ferr_d;
            abort_q   <= abort_d;
        end
    end

    // next state, byte assembly, one-deep hold so the last byte can carry eof
    always_comb begin
        state_d   = state;
        pre_cnt_d = pre_cnt;
        asm_d     = asm_q;
        hold_d    = hold_q;
        sym_d     = sym_cnt;
        hold_v_d  = hold_v;
        sof_d     = sof_done;
        ferr_d    = frame_err;
        abort_d   = abort_q;
        push      = 1'b0;
        push_e    = '0;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_en && i_rx_dv && i_rx_data == P_SYM) begin
                    state_d   = ST_PRE;
                    pre_cnt_d = 8'd1;
                end
            end
            ST_PRE: begin
                if (i_rx_en) begin
                    if (!i_rx_dv) state_d = ST_IDLE;
                    else if (i_rx_data == P_SYM) pre_cnt_d = pre_cnt + {7'd0, pre_cnt != 8'hFF};
                    else if (i_rx_data == S_SYM && pre_cnt >= MIN_PRE) begin
                        state_d  = ST_DATA;
                        asm_d    = '0;
                        sym_d    = '0;
                        hold_v_d = 1'b0;
                        sof_d    = 1'b0;
                        ferr_d   = 1'b0;
                    end else state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (i_rx_en) begin
                    if (i_rx_dv) begin
                        asm_d  = asm_nx;
                        ferr_d = frame_err | i_rx_er;
                        sym_d  = byte_done ? 2'd0 : sym_cnt + 2'd1;
                        if (byte_done) begin
                            hold_v_d = 1'b1;
                            hold_d   = asm_nx;
                            push     = hold_v;
                            push_e   = '{sof: !sof_done, eof: 1'b0, err: 1'b0, data: hold_q};
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        hold_v_d = 1'b0;
                        push     = hold_v;
                        push_e   = '{sof: !sof_done, eof: 1'b1, err: frame_err | (sym_cnt != 2'd0), data: hold_q};
                        err_inc  = !hold_v;
                    end
                    if (push) begin
                        if (full) begin
                            state_d  = ST_DROP;
                            abort_d  = sof_done;
                            hold_v_d = 1'b0;
                            drop_inc = 1'b1;
                        end else begin
                            sof_d   = 1'b1;
                            ok_inc  = push_e.eof & !push_e.err;
                            err_inc = push_e.eof & push_e.err;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (abort_q && !full) begin
                    push    = 1'b1;
                    push_e  = '{sof: 1'b0, eof: 1'b1, err: 1'b1, data: 8'h00};
                    abort_d = 1'b0;
                end
                if (i_rx_en && !i_rx_dv && !abort_q) state_d = ST_IDLE;
            end
        endcase
    end

    mii_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_entry   (push_e),
        .i_pop     (o_valid & i_ready),
        .o_entry   (head),
        .o_full    (full),
        .o_empty   (empty)
    );

    assign o_valid = !empty;
    assign {o_sof, o_eof, o_err, o_data} = head;

`ifdef MII_RX_DEFRAMER_STATS_EN
    logic [15:0] ok_q, err_q, drop_q;

    // saturating frame outcome counters
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ok_q   <= '0;
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            if (ok_inc && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
            if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign o_frames_ok   = ok_q;
    assign o_frames_err  = err_q;
    assign o_frames_drop = drop_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{ok_inc, err_inc, drop_inc};
    assign o_frames_ok   = '0;
    assign o_frames_err  = '0;
    assign o_frames_drop = '0;
`endif

endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: directed frames on 2/4/8-bit lanes checked against a frame-level scoreboard
module tb_mii_rx_deframer;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic       err;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dv2 = 1'b0;
    logic       dv4 = 1'b0;
    logic       dv8 = 1'b0;
    logic       er = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic [3:0] rdy = 4'hF;
    logic [3:0] v, so, eo, eb;
    logic [7:0] dat [4];
    logic [15:0] cok [4];
    logic [15:0] cerr [4];
    logic [15:0] cdrop [4];

    int   ncmp = 0;
    int   nfail = 0;
    ent_t q [4][$];
    int   npop [4];
    ent_t last [4];
    ent_t first [4];
    ent_t held [4];
    logic [3:0] hold_chk = 4'h0;
    int   exp_ok [4];
    int   exp_err [4];
    int   exp_drop [4];
    logic [7:0] fb [256];

    always #5 clk = ~clk;

    // index 0: 4-bit lane, 16 deep; 1: 4-bit lane, 4 deep (same lane); 2: 2-bit lane; 3: 8-bit lane
    mii_rx_deframer #(.LANE_W(4), .FIFO_DEPTH(16), .MIN_PRE_SYM(4)) u4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_en(en), .i_rx_dv(dv4), .i_rx_er(er), .i_rx_data(rxd[3:0]),
        .o_valid(v[0]), .i_ready(rdy[0]), .o_data(dat[0]), .o_sof(so[0]), .o_eof(eo[0]), .o_err(eb[0]),
        .o_frames_ok(cok[0]), .o_frames_err(cerr[0]), .o_frames_drop(cdrop[0]));
    mii_rx_deframer #(.LANE_W(4), .FIFO_DEPTH(4), .MIN_PRE_SYM(4)) u4s (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_en(en), .i_rx_dv(dv4), .i_rx_er(er), .i_rx_data(rxd[3:0]),
        .o_valid(v[1]), .i_ready(rdy[1]), .o_data(dat[1]), .o_sof(so[1]), .o_eof(eo[1]), .o_err(eb[1]),
        .o_frames_ok(cok[1]), .o_frames_err(cerr[1]), .o_frames_drop(cdrop[1]));
    mii_rx_deframer #(.LANE_W(2), .FIFO_DEPTH(16), .MIN_PRE_SYM(4)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_en(en), .i_rx_dv(dv2), .i_rx_er(er), .i_rx_data(rxd[1:0]),
        .o_valid(v[2]), .i_ready(rdy[2]), .o_data(dat[2]), .o_sof(so[2]), .o_eof(eo[2]), .o_err(eb[2]),
        .o_frames_ok(cok[2]), .o_frames_err(cerr[2]), .o_frames_drop(cdrop[2]));
    mii_rx_deframer #(.LANE_W(8), .FIFO_DEPTH(16), .MIN_PRE_SYM(4)) u8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_en(en), .i_rx_dv(dv8), .i_rx_er(er), .i_rx_data(rxd),
        .o_valid(v[3]), .i_ready(rdy[3]), .o_data(dat[3]), .o_sof(so[3]), .o_eof(eo[3]), .o_err(eb[3]),
        .o_frames_ok(cok[3]), .o_frames_err(cerr[3]), .o_frames_drop(cdrop[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // scoreboard compare: every accepted entry, plus stability while stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) hold_chk = 4'h0;
        else for (int i = 0; i < 4; i++) begin
            ent_t cur;
            ent_t e;
            cur = {so[i], eo[i], eb[i], dat[i]};
            if (hold_chk[i]) check($sformatf("stall_hold%0d", i), 32'({v[i], cur}), 32'({1'b1, held[i]}));
            if (v[i] && rdy[i]) begin
                if (q[i].size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_entry%0d: got %0h, expected no entry", i, cur);
                end else begin
                    e = q[i].pop_front();
                    check($sformatf("entry%0d_%0d", i, npop[i]), 32'(cur), 32'(e));
                    npop[i]++;
                    last[i] = cur;
                    if (cur.sof) first[i] = cur;
                end
            end
            hold_chk[i] = v[i] & ~rdy[i];
            held[i] = cur;
        end
    end

    task automatic fill(input int n, input int seed);
        for (int i = 0; i < n; i++) fb[i] = 8'(i * 37 + seed);
    endtask

    // frame-level expectation: n bytes, bad eof flag, cap = FIFO room if nothing drains (0 = drains)
    task automatic expect_frame(input int i, input int n, input bit bad, input int cap, input bit open_end);
        int kept;
        kept = (cap > 0 && n > cap) ? cap : n;
        if (open_end) kept = n - 1;
        for (int b = 0; b < kept; b++) begin
            ent_t e;
            e.sof = b == 0;
            e.eof = !open_end && kept == n && b == n - 1;
            e.err = e.eof && bad;
            e.data = fb[b];
            q[i].push_back(e);
        end
        if (!open_end) begin
            if (kept < n) begin
                q[i].push_back(ent_t'({1'b0, 1'b1, 1'b1, 8'h00}));
                exp_drop[i]++;
            end else if (n == 0 || bad) exp_err[i]++;
            else exp_ok[i]++;
        end
    endtask

    task automatic sym(input int w, input logic d_v, input logic d_er, input logic [7:0] d);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            rxd = 8'($urandom);
            er = 1'($urandom);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        dv2 = d_v && w == 2;
        dv4 = d_v && w == 4;
        dv8 = d_v && w == 8;
        er = d_er;
        rxd = d;
    endtask

    task automatic send_frame(input int w, input int npre, input int nbytes, input int er_at, input int extra, input bit open_end);
        logic [7:0] p, s, m;
        p = w == 2 ? 8'h01 : w == 4 ? 8'h05 : 8'h55;
        s = w == 2 ? 8'h03 : w == 4 ? 8'h0D : 8'hD5;
        m = 8'((1 << w) - 1);
        for (int i = 0; i < npre; i++) sym(w, 1'b1, 1'b0, p);
        sym(w, 1'b1, 1'b0, s);
        for (int i = 0; i < nbytes; i++)
            for (int k = 0; k < 8 / w; k++) sym(w, 1'b1, i == er_at && k == 0, (fb[i] >> (k * w)) & m);
        for (int k = 0; k < extra; k++) sym(w, 1'b1, 1'b0, 8'h0A & m);
        if (!open_end) repeat (3) sym(w, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en = 1'b1;
            dv2 = 1'b0;
            dv4 = 1'b0;
            dv8 = 1'b0;
            er = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_in_time", 32'(t < 500), 32'd1);
        idle(4);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) npop[i] = 0;
    endtask

    task automatic check_counters();
        for (int i = 0; i < 4; i++) begin
`ifdef MII_RX_DEFRAMER_STATS_EN
            check($sformatf("frames_ok%0d", i), 32'(cok[i]), 32'(exp_ok[i]));
            check($sformatf("frames_err%0d", i), 32'(cerr[i]), 32'(exp_err[i]));
            check($sformatf("frames_drop%0d", i), 32'(cdrop[i]), 32'(exp_drop[i]));
`else
            check($sformatf("frames_ok%0d", i), 32'(cok[i]), 32'd0);
            check($sformatf("frames_err%0d", i), 32'(cerr[i]), 32'd0);
            check($sformatf("frames_drop%0d", i), 32'(cdrop[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_ok[i] = 0;
            exp_err[i] = 0;
            exp_drop[i] = 0;
        end
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_valid%0d", i), 32'(v[i]), 32'd0);
            check($sformatf("reset_out%0d", i), 32'({so[i], eo[i], eb[i], dat[i]}), 32'd0);
        end
        check_counters();
        rst_n = 1'b1;
        idle(4);

        // 64-byte good frame after 7 preamble symbols
        fill(64, 5);
        expect_frame(0, 64, 1'b0, 0, 1'b0);
        expect_frame(1, 64, 1'b0, 0, 1'b0);
        send_frame(4, 7, 64, -1, 0, 1'b0);
        drain();
        check("t1_count", 32'(npop[0]), 32'd64);
        check("t1_first", 32'(first[0]), 32'({1'b1, 1'b0, 1'b0, 8'h05}));
        check("t1_last", 32'(last[0]), 32'({1'b0, 1'b1, 1'b0, 8'h20}));
        clear_counts();

        // receive error pulsed at byte 10
        fill(20, 9);
        expect_frame(0, 20, 1'b1, 0, 1'b0);
        expect_frame(1, 20, 1'b1, 0, 1'b0);
        send_frame(4, 7, 20, 10, 0, 1'b0);
        drain();
        check("t2_count", 32'(npop[0]), 32'd20);
        check("t2_last", 32'(last[0]), 32'({1'b0, 1'b1, 1'b1, 8'hC8}));
        clear_counts();

        // 41 nibbles: trailing half byte marks the frame bad
        fill(20, 1);
        expect_frame(0, 20, 1'b1, 0, 1'b0);
        expect_frame(1, 20, 1'b1, 0, 1'b0);
        send_frame(4, 7, 20, -1, 1, 1'b0);
        drain();
        check("t3_count", 32'(npop[0]), 32'd20);
        check("t3_last", 32'(last[0]), 32'({1'b0, 1'b1, 1'b1, 8'hC0}));
        clear_counts();

        // overflow on the 4-deep instance while its consumer stalls
        rdy[1] = 1'b0;
        fill(10, 3);
        expect_frame(0, 10, 1'b0, 0, 1'b0);
        expect_frame(1, 10, 1'b0, 4, 1'b0);
        send_frame(4, 7, 10, -1, 0, 1'b0);
        idle(10);
        rdy[1] = 1'b1;
        drain();
        check("t4_small_count", 32'(npop[1]), 32'd5);
        check("t4_marker", 32'(last[1]), 32'({1'b0, 1'b1, 1'b1, 8'h00}));
        check("t4_wide_count", 32'(npop[0]), 32'd10);
        clear_counts();

        // too-short preamble produces nothing
        send_frame(4, 2, 0, -1, 0, 1'b0);
        idle(10);
        check("t5_count", 32'(npop[0] + npop[1]), 32'd0);
        check("t5_valid", 32'(v[1:0]), 32'd0);

        // SFD followed by dv low: empty frame, counted as error
        expect_frame(0, 0, 1'b0, 0, 1'b0);
        expect_frame(1, 0, 1'b0, 0, 1'b0);
        send_frame(4, 7, 0, -1, 0, 1'b0);
        idle(10);
        check("t6_valid", 32'(v[1:0]), 32'd0);
        check_counters();

        // reset in the middle of a frame with bytes queued
        rdy[0] = 1'b0;
        fill(5, 7);
        expect_frame(0, 5, 1'b0, 0, 1'b1);
        expect_frame(1, 5, 1'b0, 0, 1'b1);
        send_frame(4, 7, 5, -1, 0, 1'b1);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t7_pre_valid", 32'(v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_valid_cleared", 32'(v), 32'd0);
        dv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            exp_ok[i] = 0;
            exp_err[i] = 0;
            exp_drop[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy[0] = 1'b1;
        idle(4);
        clear_counts();
        fill(16, 11);
        expect_frame(0, 16, 1'b0, 0, 1'b0);
        expect_frame(1, 16, 1'b0, 0, 1'b0);
        send_frame(4, 7, 16, -1, 0, 1'b0);
        drain();
        check("t7_count", 32'(npop[0]), 32'd16);
        check("t7_first", 32'(first[0]), 32'({1'b1, 1'b0, 1'b0, 8'h0B}));

        // RMII and GMII lanes
        fill(64, 5);
        expect_frame(2, 64, 1'b0, 0, 1'b0);
        send_frame(2, 7, 64, -1, 0, 1'b0);
        drain();
        check("t8_count", 32'(npop[2]), 32'd64);
        check("t8_last", 32'(last[2]), 32'({1'b0, 1'b1, 1'b0, 8'h20}));
        fill(64, 13);
        expect_frame(3, 64, 1'b0, 0, 1'b0);
        send_frame(8, 7, 64, -1, 0, 1'b0);
        drain();
        check("t9_count", 32'(npop[3]), 32'd64);
        check("t9_first", 32'(first[3]), 32'({1'b1, 1'b0, 1'b0, 8'h0D}));

        check_counters();
        for (int i = 0; i < 4; i++) check($sformatf("queue_empty%0d", i), 32'(q[i].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
